// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal-sync port arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fractal_sync_pkg;

    // Per-requester slot state: free, waiting for a grant, waiting for a response.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_WAIT = 2'd2
    } fsync_arb_state_e;

    // Index that lies 'off' places after 'base' in a ring of 'n' entries.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fractal_sync_rr_arbiter.sv
// Round-robin pick among N requests, starting just after a pointer held by the parent.
// Latency: purely combinational.
// Backpressure: none; the parent decides when a grant takes effect.
//   req     : requests, one bit per requester
//   ptr     : index of the last grantee
//   gnt     : one-hot grant, gnt_idx its index, any_gnt set when gnt is non-zero
module fractal_sync_rr_arbiter
    import fractal_sync_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    int unsigned cand;

    // Offsets 1..N visit every index once, the pointer itself last,
    // so the previous grantee has the lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = rr_wrap(32'(ptr), 32'(k), 32'(N));
            if (!any_gnt && req[cand]) begin
                any_gnt   = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fractal_sync_port_arbiter.sv
// Shares one fractal-sync upstream port among N_REQ requesters: one pending request per
// requester, round-robin grant, tag-routed responses, per-requester timeout.
// Latency: accept at edge t -> upstream request in cycle t+2; response at edge e -> rsp pulse after e.
// Backpressure: req_ready_o low while a requester's slot is busy; the upstream side has none.
//   req_valid_i/req_level_i/req_ready_o : per-requester request handshake, level flattened
//   rsp_valid_o/rsp_error_o             : per-requester one-cycle response pulse and error flag
//   up_req_*                            : registered upstream request, tagged with requester index
//   up_rsp_*                            : upstream response, routed by tag
//   spurious_o                          : pulse when a response matches no waiting requester
module fractal_sync_port_arbiter
    import fractal_sync_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int LVL_W   = 4,
    parameter  int TIMEOUT = 1024,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*LVL_W-1:0] req_level_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [N_REQ-1:0]       rsp_valid_o,
    output logic [N_REQ-1:0]       rsp_error_o,
    output logic                   up_req_valid_o,
    output logic [LVL_W-1:0]       up_req_level_o,
    output logic [ID_W-1:0]        up_req_id_o,
    input  logic                   up_rsp_valid_i,
    input  logic [ID_W-1:0]        up_rsp_id_i,
    input  logic                   up_rsp_error_i,
    output logic                   spurious_o
);

    // Timer must be able to hold TIMEOUT; keep at least one bit when timeout is disabled.
    localparam int          TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [N_REQ-1:0]       idle_v;
    logic [N_REQ-1:0]       pend_v;
    logic [N_REQ-1:0]       rsp_hit;
    logic [N_REQ*LVL_W-1:0] level_flat;

    logic [ID_W-1:0]        ptr_q;
    logic [N_REQ-1:0]       gnt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   any_gnt;

    fractal_sync_rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr (
        .req     (pend_v),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign req_ready_o = idle_v;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        fsync_arb_state_e state_q, state_d;
        logic [LVL_W-1:0] level_q;
        logic [TW-1:0]    timer_q;
        logic             is_idle, is_pend, is_wait;
        logic             hit, to_hit;
        logic             rsp_vld_q, rsp_err_q;

        // A response only counts for a requester that is actually waiting on it.
        assign hit    = up_rsp_valid_i && (up_rsp_id_i == ID_W'(i)) && is_wait;
        // A response landing in the timeout cycle takes precedence.
        assign to_hit = (TIMEOUT != 0) && is_wait && !hit && (timer_q == TW'(TO_LAST));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ARB_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ARB_IDLE: if (req_valid_i[i])  state_d = ARB_PEND;
                ARB_PEND: if (gnt[i])          state_d = ARB_WAIT;
                ARB_WAIT: if (hit || to_hit)   state_d = ARB_IDLE;
                default:                       state_d = ARB_IDLE;
            endcase
        end

        always_comb begin
            is_idle = (state_q == ARB_IDLE);
            is_pend = (state_q == ARB_PEND);
            is_wait = (state_q == ARB_WAIT);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                level_q   <= '0;
                timer_q   <= '0;
                rsp_vld_q <= 1'b0;
                rsp_err_q <= 1'b0;
            end else begin
                if (is_idle && req_valid_i[i]) begin
                    level_q <= req_level_i[i*LVL_W +: LVL_W];
                end
                // Clear on entry to WAIT, then count every WAIT cycle, saturating.
                if (is_pend && gnt[i]) begin
                    timer_q <= '0;
                end else if (is_wait && (timer_q != '1)) begin
                    timer_q <= timer_q + 1'b1;
                end
                rsp_vld_q <= hit || to_hit;
                rsp_err_q <= hit ? up_rsp_error_i : to_hit;
            end
        end

        assign idle_v[i]                       = is_idle;
        assign pend_v[i]                       = is_pend;
        assign rsp_hit[i]                      = hit;
        assign level_flat[i*LVL_W +: LVL_W]    = level_q;
        assign rsp_valid_o[i]                  = rsp_vld_q;
        assign rsp_error_o[i]                  = rsp_err_q;
    end

    // Pointer, upstream request register and spurious-response flag.
    // Any response that hit no waiting requester (wrong state or out-of-range tag) is spurious.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q          <= ID_W'(N_REQ - 1);
            up_req_valid_o <= 1'b0;
            up_req_level_o <= '0;
            up_req_id_o    <= '0;
            spurious_o     <= 1'b0;
        end else begin
            if (any_gnt) begin
                ptr_q <= gnt_idx;
            end
            up_req_valid_o <= any_gnt;
            up_req_id_o    <= any_gnt ? gnt_idx : '0;
            up_req_level_o <= any_gnt ? level_flat[int'(gnt_idx)*LVL_W +: LVL_W] : '0;
            spurious_o     <= up_rsp_valid_i && !(|rsp_hit);
        end
    end

endmodule

// File: tb/tb_fractal_sync_port_arbiter.sv
// Directed self-checking bench for fractal_sync_port_arbiter (N_REQ=4, LVL_W=4, TIMEOUT=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_fractal_sync_port_arbiter;

    localparam int N_REQ   = 4;
    localparam int LVL_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*LVL_W-1:0] req_level;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_error;
    logic                   up_req_valid;
    logic [LVL_W-1:0]       up_req_level;
    logic [ID_W-1:0]        up_req_id;
    logic                   up_rsp_valid;
    logic [ID_W-1:0]        up_rsp_id;
    logic                   up_rsp_error;
    logic                   spurious;

    int n_cmp = 0;
    int n_bad = 0;

    fractal_sync_port_arbiter #(
        .N_REQ   (N_REQ),
        .LVL_W   (LVL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_level_i    (req_level),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_error_o    (rsp_error),
        .up_req_valid_o (up_req_valid),
        .up_req_level_o (up_req_level),
        .up_req_id_o    (up_req_id),
        .up_rsp_valid_i (up_rsp_valid),
        .up_rsp_id_i    (up_rsp_id),
        .up_rsp_error_i (up_rsp_error),
        .spurious_o     (spurious)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_level(input int idx, input logic [LVL_W-1:0] v);
        req_level[idx*LVL_W +: LVL_W] = v;
    endtask

    task automatic send_rsp(input logic [ID_W-1:0] id, input logic err);
        up_rsp_valid = 1'b1;
        up_rsp_id    = id;
        up_rsp_error = err;
    endtask

    task automatic clear_rsp();
        up_rsp_valid = 1'b0;
        up_rsp_id    = '0;
        up_rsp_error = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_level = '0;
        clear_rsp();

        // 1: reset state and quiet idle port
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_ready",    32'(req_ready),    32'hF);
        check_eq("rst_rspv",     32'(rsp_valid),    32'h0);
        check_eq("rst_rspe",     32'(rsp_error),    32'h0);
        check_eq("rst_upv",      32'(up_req_valid), 32'h0);
        check_eq("rst_uplvl",    32'(up_req_level), 32'h0);
        check_eq("rst_upid",     32'(up_req_id),    32'h0);
        check_eq("rst_spur",     32'(spurious),     32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq("idle_upv", 32'(up_req_valid), 32'h0);
        end

        // 2: single request from 2, level 3
        req_valid = 4'b0100;
        set_level(2, 4'd3);
        tick();
        req_valid = '0;
        check_eq("s_ready",  32'(req_ready),    32'hB);
        check_eq("s_upv_t1", 32'(up_req_valid), 32'h0);
        tick();
        check_eq("s_upv",    32'(up_req_valid), 32'h1);
        check_eq("s_upid",   32'(up_req_id),    32'h2);
        check_eq("s_uplvl",  32'(up_req_level), 32'h3);
        tick();
        check_eq("s_upv_t3", 32'(up_req_valid), 32'h0);
        send_rsp(2'd2, 1'b0);
        tick();
        clear_rsp();
        check_eq("s_rspv",   32'(rsp_valid),    32'h4);
        check_eq("s_rspe",   32'(rsp_error),    32'h0);
        check_eq("s_ready2", 32'(req_ready),    32'hF);
        check_eq("s_spur",   32'(spurious),     32'h0);
        tick();
        check_eq("s_rspv_end", 32'(rsp_valid),  32'h0);

        // 3: fairness from a fresh pointer (reset -> requester 0 first)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < N_REQ; k++) set_level(k, LVL_W'(4 + k));
        tick();
        req_valid = '0;
        check_eq("f_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < N_REQ; k++) begin
            tick();
            check_eq("f_upv",   32'(up_req_valid), 32'h1);
            check_eq("f_upid",  32'(up_req_id),    32'(k));
            check_eq("f_uplvl", 32'(up_req_level), 32'(4 + k));
        end
        for (int k = 0; k < N_REQ; k++) begin
            send_rsp(ID_W'(k), 1'b0);
            tick();
            check_eq("f_rspv", 32'(rsp_valid), 32'(1 << k));
            if (k == 0) check_eq("f_upv_done", 32'(up_req_valid), 32'h0);
        end
        clear_rsp();
        tick();
        check_eq("f_rspv_end", 32'(rsp_valid), 32'h0);
        check_eq("f_ready2",   32'(req_ready), 32'hF);
        // pointer is 3: requester 0 must beat requester 3
        req_valid = 4'b1001;
        set_level(0, 4'd9);
        set_level(3, 4'd10);
        tick();
        req_valid = '0;
        tick();
        check_eq("f2_upid0",  32'(up_req_id),    32'h0);
        check_eq("f2_uplvl0", 32'(up_req_level), 32'h9);
        tick();
        check_eq("f2_upv3",   32'(up_req_valid), 32'h1);
        check_eq("f2_upid3",  32'(up_req_id),    32'h3);
        check_eq("f2_uplvl3", 32'(up_req_level), 32'hA);
        send_rsp(2'd0, 1'b1);
        tick();
        check_eq("f2_rspv0", 32'(rsp_valid), 32'h1);
        check_eq("f2_rspe0", 32'(rsp_error), 32'h1);
        send_rsp(2'd3, 1'b0);
        tick();
        clear_rsp();
        check_eq("f2_rspv3", 32'(rsp_valid), 32'h8);
        check_eq("f2_rspe3", 32'(rsp_error), 32'h0);
        tick();

        // 4: timeout of requester 1 after 8 WAIT cycles, then a late response
        req_valid = 4'b0010;
        set_level(1, 4'd5);
        tick();
        req_valid = '0;
        tick();
        check_eq("t_upv",  32'(up_req_valid), 32'h1);
        check_eq("t_upid", 32'(up_req_id),    32'h1);
        repeat (7) tick();
        check_eq("t_early", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("t_rspv", 32'(rsp_valid), 32'h2);
        check_eq("t_rspe", 32'(rsp_error), 32'h2);
        tick();
        check_eq("t_rspv_end", 32'(rsp_valid), 32'h0);
        check_eq("t_ready",    32'(req_ready), 32'hF);
        send_rsp(2'd1, 1'b0);
        tick();
        clear_rsp();
        check_eq("t_late_spur", 32'(spurious),  32'h1);
        check_eq("t_late_rspv", 32'(rsp_valid), 32'h0);
        tick();
        check_eq("t_spur_end", 32'(spurious), 32'h0);

        // 5a: response arrives in the very cycle requester 0 would time out
        req_valid = 4'b0001;
        set_level(0, 4'd2);
        tick();
        req_valid = '0;
        tick();
        repeat (7) tick();
        send_rsp(2'd0, 1'b0);
        tick();
        clear_rsp();
        check_eq("c_rspv", 32'(rsp_valid), 32'h1);
        check_eq("c_rspe", 32'(rsp_error), 32'h0);
        check_eq("c_spur", 32'(spurious),  32'h0);
        tick();
        check_eq("c_rspv_end", 32'(rsp_valid), 32'h0);

        // 5b: response tagged 3 while 3 is still PEND, grant to 3 proceeds
        req_valid = 4'b1000;
        set_level(3, 4'd12);
        tick();
        req_valid = '0;
        send_rsp(2'd3, 1'b0);
        tick();
        clear_rsp();
        check_eq("p_spur",  32'(spurious),     32'h1);
        check_eq("p_rspv",  32'(rsp_valid),    32'h0);
        check_eq("p_upv",   32'(up_req_valid), 32'h1);
        check_eq("p_upid",  32'(up_req_id),    32'h3);
        check_eq("p_uplvl", 32'(up_req_level), 32'hC);
        send_rsp(2'd3, 1'b0);
        tick();
        clear_rsp();
        check_eq("p_rspv3", 32'(rsp_valid), 32'h8);
        check_eq("p_spur2", 32'(spurious),  32'h0);
        tick();

        // 6: reset with two requesters in WAIT, then a stale response
        req_valid = 4'b0011;
        tick();
        req_valid = '0;
        tick();
        tick();
        check_eq("r_ready_wait", 32'(req_ready),    32'hC);
        check_eq("r_upv_pre",    32'(up_req_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("r_ready", 32'(req_ready),    32'hF);
        check_eq("r_upv",   32'(up_req_valid), 32'h0);
        send_rsp(2'd0, 1'b0);
        tick();
        clear_rsp();
        check_eq("r_spur", 32'(spurious),  32'h1);
        check_eq("r_rspv", 32'(rsp_valid), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
